alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_if.sv | 28 ++
 rtl/alu_pipe.sv | 177 +++++++++++++++++
 tb/tb_alu_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Request/result bus for alu_pipe: operands and opcode in, registered result and flags out.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both 1; the sender
// holds valid and its payload until that edge, and ready may depend on the receiver's state only.
interface alu_pipe_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;
  logic             illegal_op;

  modport master (
    output in_valid, a, b, alu_op, out_ready,
    input  in_ready, out_valid, result, zero, negative, carry, overflow, illegal_op
  );

  modport slave (
    input  in_valid, a, b, alu_op, out_ready,
    output in_ready, out_valid, result, zero, negative, carry, overflow, illegal_op
  );
endinterface

// File: rtl/alu_pipe.sv
// Single-issue ALU with a one-entry registered output stage. Define ALU_PIPE_MUL_EN to build the
// iterative shift-add multiplier (opcode 0011) and its IDLE/BUSY FSM; otherwise 0011 is illegal.
module alu_pipe #(
  parameter int WIDTH = 64
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_pipe_if.slave bus,
  output logic      fsm_busy
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLT = 4'b0111;

  logic             accept;
  logic             start_mul;
  logic             busy;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_ill;

  logic             ld_en;
  logic [WIDTH-1:0] ld_res;
  logic             ld_c;
  logic             ld_v;
  logic             ld_ill;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             neg_q;
  logic             carry_q;
  logic             ovf_q;
  logic             ill_q;

`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam int         CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             mul_last;

  assign busy      = (state == BUSY);
  assign start_mul = accept && (bus.alu_op == OP_MUL);
  // One partial product per cycle: multiplicand walks left while multiplier bits are consumed LSB first.
  assign acc_next  = acc + (mplier[0] ? mcand : '0);
  assign mul_last  = busy && (cnt == LAST);
`else
  assign busy      = 1'b0;
  assign start_mul = 1'b0;
`endif

  assign bus.in_ready = rst_n && !busy && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign fsm_busy     = busy;

  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.zero       = zero_q;
  assign bus.negative   = neg_q;
  assign bus.carry      = carry_q;
  assign bus.overflow   = ovf_q;
  assign bus.illegal_op = ill_q;

  always_comb begin
    sum     = {1'b0, bus.a} + {1'b0, bus.b};
    diff    = {1'b0, bus.a} - {1'b0, bus.b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (bus.alu_op)
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_NOR: alu_res = ~(bus.a | bus.b);
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        // diff[WIDTH] is the borrow, so carry reads as a >= b unsigned.
        alu_res = diff[WIDTH-1:0];
        alu_c   = ~diff[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    ld_en  = accept && !start_mul;
    ld_res = alu_res;
    ld_c   = alu_c;
    ld_v   = alu_v;
    ld_ill = alu_ill;
`ifdef ALU_PIPE_MUL_EN
    if (mul_last) begin
      ld_en  = 1'b1;
      ld_res = acc_next;
      ld_c   = 1'b0;
      ld_v   = 1'b0;
      ld_ill = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      state       <= IDLE;
      cnt         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
`endif
    end else begin
      if (ld_en) begin
        out_valid_q <= 1'b1;
        result_q    <= ld_res;
        zero_q      <= (ld_res == '0);
        neg_q       <= ld_res[WIDTH-1];
        carry_q     <= ld_c;
        ovf_q       <= ld_v;
        ill_q       <= ld_ill;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
`ifdef ALU_PIPE_MUL_EN
      case (state)
        IDLE: begin
          if (start_mul) begin
            state  <= BUSY;
            cnt    <= '0;
            mcand  <= bus.a;
            mplier <= bus.b;
            acc    <= '0;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases plus a randomized stream checked
// against an arithmetic reference model; MUL scenarios are built when ALU_PIPE_MUL_EN is defined.
module tb_alu_pipe;
  localparam int W = 64;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b0011;

  logic clk = 1'b0;
  logic rst_n;
  logic fsm_busy;
  int   tests_run = 0;
  int   tests_failed = 0;

  // Expected entries are {illegal_op, overflow, carry, negative, zero, result}.
  logic [W+4:0] exp_q[$];

  alu_pipe_if #(.WIDTH(W)) bus();

  alu_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .fsm_busy (fsm_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W+4:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]        r;
    logic                c, v, ill;
    logic signed [W+1:0] sa, sb, ss, maxs, mins;
    logic [2*W-1:0]      prod;
    r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
    sa   = $signed(a);
    sb   = $signed(b);
    maxs = {3'b000, {(W-1){1'b1}}};
    mins = -maxs - 1;
    ss   = '0;
    prod = '0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOR: r = ~(a | b);
      OP_ADD: begin
        r  = a + b;
        c  = (r < a);
        ss = sa + sb;
        v  = (ss > maxs) || (ss < mins);
      end
      OP_SUB: begin
        r  = a - b;
        c  = (a >= b);
        ss = sa - sb;
        v  = (ss > maxs) || (ss < mins);
      end
      OP_SLT: r = (sa < sb) ? 1 : 0;
`ifdef ALU_PIPE_MUL_EN
      OP_MUL: begin
        prod = a * b;
        r    = prod[W-1:0];
      end
`endif
      default: ill = 1'b1;
    endcase
    return {ill, v, c, r[W-1], (r == '0), r};
  endfunction

  function automatic logic [W+4:0] observed();
    return {bus.illegal_op, bus.overflow, bus.carry, bus.negative, bus.zero, bus.result};
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] x;
    case ($urandom_range(0, 5))
      0: x = '0;
      1: x = '1;
      2: x = {1'b1, {(W-1){1'b0}}};
      3: x = {1'b0, {(W-1){1'b1}}};
      default: x = {$urandom, $urandom};
    endcase
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = v;
    bus.alu_op   = op;
    bus.a        = a;
    bus.b        = b;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, OP_ADD, 64'd1, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    tests_run++;
    if (observed() !== '0) begin tests_failed++; $display("FAIL reset_outputs got %h want 0", observed()); end
    drive(1'b0, OP_AND, '0, '0);
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_add_sub_slt();
    logic [W+4:0] e;
    bus.out_ready = 1'b1;
    drive(1'b1, OP_ADD, '1, 64'd1);
    tick();
    drive(1'b0, OP_AND, '0, '0);
    tests_run++;
    if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL add_latency out_valid got %b want 1", bus.out_valid); end
    e = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0};
    tests_run++;
    if (observed() !== e) begin tests_failed++; $display("FAIL add_wrap got %h want %h", observed(), e); end

    drive(1'b1, OP_SUB, 64'h8000_0000_0000_0000, 64'd1);
    tick();
    drive(1'b0, OP_AND, '0, '0);
    e = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF};
    tests_run++;
    if (observed() !== e) begin tests_failed++; $display("FAIL sub_overflow got %h want %h", observed(), e); end

    drive(1'b1, OP_SLT, '1, 64'd0);
    tick();
    drive(1'b0, OP_AND, '0, '0);
    e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h1};
    tests_run++;
    if (observed() !== e) begin tests_failed++; $display("FAIL slt_signed got %h want %h", observed(), e); end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_clear out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_illegal();
    logic [W+4:0] e;
    e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0};
    bus.out_ready = 1'b1;
    drive(1'b1, 4'b1111, '1, '1);
    tick();
    drive(1'b0, OP_AND, '0, '0);
    tests_run++;
    if (bus.out_valid !== 1'b1 || observed() !== e) begin
      tests_failed++; $display("FAIL illegal_1111 valid %b got %h want %h", bus.out_valid, observed(), e);
    end
`ifndef ALU_PIPE_MUL_EN
    drive(1'b1, OP_MUL, 64'h123, 64'h100);
    tick();
    drive(1'b0, OP_AND, '0, '0);
    tests_run++;
    if (bus.out_valid !== 1'b1 || observed() !== e) begin
      tests_failed++; $display("FAIL illegal_mul_disabled valid %b got %h want %h", bus.out_valid, observed(), e);
    end
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a0, b0;
    logic [3:0]   ops[3];
    logic [W+4:0] held;
    ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_NOR;
    held = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a0 = rand_operand();
      b0 = rand_operand();
      drive(1'b1, ops[i], a0, b0);
      held = model(ops[i], a0, b0);
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b1 || observed() !== held) begin
        tests_failed++; $display("FAIL b2b_op%0d valid %b got %h want %h", i, bus.out_valid, observed(), held);
      end
    end
    bus.out_ready = 1'b0;
    drive(1'b1, OP_ADD, 64'd7, 64'd9);
    #1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || observed() !== held) begin
        tests_failed++;
        $display("FAIL stall_hold cyc%0d in_ready %b valid %b got %h want %h", i, bus.in_ready, bus.out_valid, observed(), held);
      end
      tick();
    end
    drive(1'b0, OP_AND, '0, '0);
    bus.out_ready = 1'b1;
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_drain out_valid got %b want 0", bus.out_valid); end
  endtask

`ifdef ALU_PIPE_MUL_EN
  task automatic test_mul();
    logic [W+4:0] e;
    e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h12300};
    bus.out_ready = 1'b1;
    drive(1'b1, OP_MUL, 64'h0123, 64'h0100);
    tick();
    drive(1'b1, OP_ADD, 64'd1, 64'd1);
    for (int i = 0; i < W; i++) begin
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || fsm_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL mul_busy cyc%0d valid %b in_ready %b busy %b", i, bus.out_valid, bus.in_ready, fsm_busy);
      end
      if (i == W - 1) drive(1'b0, OP_AND, '0, '0);
      tick();
    end
    tests_run++;
    if (bus.out_valid !== 1'b1 || observed() !== e) begin
      tests_failed++; $display("FAIL mul_result valid %b got %h want %h", bus.out_valid, observed(), e);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid_op();
    logic         saw_valid;
    logic [W+4:0] e;
`ifdef ALU_PIPE_MUL_EN
    bus.out_ready = 1'b1;
    drive(1'b1, OP_MUL, 64'h1234, 64'h5678);
    tick();
    drive(1'b0, OP_AND, '0, '0);
    repeat (5) tick();
`else
    bus.out_ready = 1'b0;
    drive(1'b1, OP_ADD, 64'h1234, 64'h5678);
    tick();
    drive(1'b0, OP_AND, '0, '0);
`endif
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset in_ready %b valid %b want 0 0", bus.in_ready, bus.out_valid);
    end
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < W + 5; i++) begin
      tick();
      if (bus.out_valid === 1'b1) saw_valid = 1'b1;
    end
    tests_run++;
    if (saw_valid !== 1'b0) begin tests_failed++; $display("FAIL aborted_op_presented got %b want 0", saw_valid); end
    drive(1'b1, OP_ADD, 64'd2, 64'd3);
    tick();
    drive(1'b0, OP_AND, '0, '0);
    e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd5};
    tests_run++;
    if (bus.out_valid !== 1'b1 || observed() !== e) begin
      tests_failed++; $display("FAIL add_after_reset valid %b got %h want %h", bus.out_valid, observed(), e);
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0]   op;
    logic [W-1:0] a0, b0;
    logic [W+4:0] e;
    exp_q.delete();
    for (int i = 0; i < 600; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      op = 4'($urandom_range(0, 15));
      a0 = rand_operand();
      b0 = rand_operand();
      drive(1'($urandom_range(0, 1)), op, a0, b0);
      #1;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL rand_unexpected got %h want none", observed());
        end else begin
          e = exp_q.pop_front();
          if (observed() !== e) begin tests_failed++; $display("FAIL rand_result got %h want %h", observed(), e); end
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) exp_q.push_back(model(op, a0, b0));
      tick();
    end
    drive(1'b0, OP_AND, '0, '0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < W + 10 && exp_q.size() > 0; i++) begin
      #1;
      if (bus.out_valid === 1'b1) begin
        tests_run++;
        e = exp_q.pop_front();
        if (observed() !== e) begin tests_failed++; $display("FAIL rand_drain got %h want %h", observed(), e); end
      end
      tick();
    end
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rand_timeout pending %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_add_sub_slt();
    test_illegal();
    test_back_to_back();
`ifdef ALU_PIPE_MUL_EN
    test_mul();
`endif
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
